// File: rtl/semaforo_ctrl_pkg.sv
// Shared definitions for the traffic-light controller: phase codes, light
// encodings and default durations, also used by the 7-segment multiplexer.
package semaforo_ctrl_pkg;

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    GREEN1   = 3'd1,
    YEL1     = 3'd2,
    ALLRED_B = 3'd3,
    GREEN2   = 3'd4,
    YEL2     = 3'd5
  } phase_t;

  // {R,G} pair per approach
  localparam logic [1:0] LIGHT_RED    = 2'b10;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b11;

  localparam int unsigned DEF_CLK_HZ   = 100_000_000;
  localparam int unsigned DEF_T_ALLRED = 2;
  localparam int unsigned DEF_T_GREEN  = 10;
  localparam int unsigned DEF_T_YELLOW = 5;
  localparam int unsigned DEF_PED_CUT  = 3;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      ALLRED_A: return GREEN1;
      GREEN1:   return YEL1;
      YEL1:     return ALLRED_B;
      ALLRED_B: return GREEN2;
      GREEN2:   return YEL2;
      default:  return ALLRED_A;
    endcase
  endfunction

  // Returns {R16, G16, R17, G17}
  function automatic logic [3:0] lights_of(input phase_t p);
    case (p)
      GREEN1:  return {LIGHT_GREEN,  LIGHT_RED};
      YEL1:    return {LIGHT_YELLOW, LIGHT_RED};
      GREEN2:  return {LIGHT_RED,    LIGHT_GREEN};
      YEL2:    return {LIGHT_RED,    LIGHT_YELLOW};
      default: return {LIGHT_RED,    LIGHT_RED};
    endcase
  endfunction

endpackage

// File: rtl/semaforo_ctrl_sec_tick_gen.sv
// Divides the system clock down to a registered one-cycle pulse every CLK_HZ
// cycles; the first pulse is consumed CLK_HZ cycles after reset release.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic CLK100MHZ,
  input  logic RST,
  output logic sec_tick
);

  localparam int unsigned CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLK_HZ - 2);

  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("sec_tick_gen: CLK_HZ must be at least 2");
  end

  logic [CW-1:0] cnt;

  // Pulse is registered from the cycle before, so it is high while cnt == LAST
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      sec_tick <= 1'b0;
    end else begin
      cnt      <= (cnt == LAST) ? '0 : cnt + CW'(1);
      sec_tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/semaforo_ctrl.sv
// Six-phase two-approach traffic-light sequencer with a 1 s tick, pedestrian
// green-cut request, and phase/countdown export for the 7-segment display.
module semaforo_ctrl
  import semaforo_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned T_ALLRED = DEF_T_ALLRED,
  parameter int unsigned T_GREEN  = DEF_T_GREEN,
  parameter int unsigned T_YELLOW = DEF_T_YELLOW,
  parameter int unsigned PED_CUT  = DEF_PED_CUT
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       BTNC,
  output logic       R16,
  output logic       G16,
  output logic       R17,
  output logic       G17,
  output logic [2:0] phase,
  output logic [5:0] remaining,
  output logic       ped_pending,
  output logic       sec_tick
);

  if (T_ALLRED < 1 || T_ALLRED > 63) begin : g_bad_allred
    $error("semaforo_ctrl: T_ALLRED out of range 1..63");
  end
  if (T_GREEN < 1 || T_GREEN > 63) begin : g_bad_green
    $error("semaforo_ctrl: T_GREEN out of range 1..63");
  end
  if (T_YELLOW < 1 || T_YELLOW > 63) begin : g_bad_yellow
    $error("semaforo_ctrl: T_YELLOW out of range 1..63");
  end
  if (PED_CUT < 1 || PED_CUT > T_GREEN) begin : g_bad_ped_cut
    $error("semaforo_ctrl: PED_CUT out of range 1..T_GREEN");
  end

  localparam logic [5:0] D_ALLRED = 6'(T_ALLRED);
  localparam logic [5:0] D_GREEN  = 6'(T_GREEN);
  localparam logic [5:0] D_YELLOW = 6'(T_YELLOW);
  localparam logic [5:0] D_PED    = 6'(PED_CUT);

  function automatic logic [5:0] dur_of(input phase_t p);
    case (p)
      GREEN1, GREEN2: return D_GREEN;
      YEL1, YEL2:     return D_YELLOW;
      default:        return D_ALLRED;
    endcase
  endfunction

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .CLK100MHZ(CLK100MHZ),
    .RST      (RST),
    .sec_tick (sec_tick)
  );

  // [0],[1] synchronise BTNC; [2] holds the previous synchronised level
  logic [2:0] btn_sync;
  logic       ped_edge;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) btn_sync <= '0;
    else     btn_sync <= {btn_sync[1:0], BTNC};
  end

  assign ped_edge = btn_sync[1] & ~btn_sync[2];

  phase_t     phase_q, phase_nxt;
  logic [5:0] rem_q, rem_nxt;
  logic       ped_q, ped_nxt;
  logic [3:0] lights_q, lights_nxt;
  logic       enter_allred;
  logic       in_green;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      phase_q  <= ALLRED_A;
      rem_q    <= D_ALLRED;
      ped_q    <= 1'b0;
      lights_q <= {LIGHT_RED, LIGHT_RED};
    end else begin
      phase_q  <= phase_nxt;
      rem_q    <= rem_nxt;
      ped_q    <= ped_nxt;
      lights_q <= lights_nxt;
    end
  end

  always_comb begin
    phase_nxt    = phase_q;
    rem_nxt      = rem_q;
    enter_allred = 1'b0;
    in_green     = (phase_q == GREEN1) || (phase_q == GREEN2);

    if (phase_q > YEL2) begin
      phase_nxt = ALLRED_A;
      rem_nxt   = D_ALLRED;
    end else if (sec_tick && rem_q == 6'd1) begin
      phase_nxt = next_phase(phase_q);
      rem_nxt   = dur_of(phase_nxt);
    end else if (ped_q && in_green && rem_q > D_PED) begin
      // the cut swallows a tick landing in the same cycle
      rem_nxt = D_PED;
    end else if (sec_tick) begin
      rem_nxt = rem_q - 6'd1;
    end

    enter_allred = (phase_nxt != phase_q) &&
                   ((phase_nxt == ALLRED_A) || (phase_nxt == ALLRED_B));
    ped_nxt      = ped_edge | (ped_q & ~enter_allred);
    lights_nxt   = lights_of(phase_nxt);
  end

  assign {R16, G16, R17, G17} = lights_q;
  assign phase       = phase_q;
  assign remaining   = rem_q;
  assign ped_pending = ped_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed self-checking bench for semaforo_ctrl with CLK_HZ = 10 and
// default durations (full light cycle = 340 clocks).
module tb_semaforo_ctrl;

  logic       CLK100MHZ = 1'b0;
  logic       RST = 1'b1;
  logic       BTNC = 1'b0;
  logic       R16, G16, R17, G17;
  logic [2:0] phase;
  logic [5:0] remaining;
  logic       ped_pending;
  logic       sec_tick;

  int n_checks = 0;
  int n_fail   = 0;

  semaforo_ctrl #(
    .CLK_HZ  (10),
    .T_ALLRED(2),
    .T_GREEN (10),
    .T_YELLOW(5),
    .PED_CUT (3)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .RST        (RST),
    .BTNC       (BTNC),
    .R16        (R16),
    .G16        (G16),
    .R17        (R17),
    .G17        (G17),
    .phase      (phase),
    .remaining  (remaining),
    .ped_pending(ped_pending),
    .sec_tick   (sec_tick)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // {R16,G16,R17,G17} per phase code, from the light table
  function automatic logic [3:0] exp_lights(input int ph);
    case (ph)
      1:       return 4'b0110;
      2:       return 4'b1110;
      4:       return 4'b1001;
      5:       return 4'b1011;
      default: return 4'b1010;
    endcase
  endfunction

  // Advance n rising edges, then stop on the following falling edge
  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    BTNC = 1'b0;
    repeat (2) @(negedge CLK100MHZ);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK100MHZ);
    n_checks++;
    if ({phase, remaining} !== {3'd0, 6'd2}) begin
      n_fail++;
      $display("FAIL reset_phase_rem: got phase=%0d rem=%0d, want 0/2", phase, remaining);
    end
    n_checks++;
    if ({R16, G16, R17, G17} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_lights: got %b, want 1010", {R16, G16, R17, G17});
    end
    n_checks++;
    if ({ped_pending, sec_tick} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got ped=%b tick=%b, want 0/0", ped_pending, sec_tick);
    end
  endtask

  task automatic test_free_run();
    int dur[6] = '{2, 10, 5, 2, 10, 5};
    int ph  = 0;
    int rem = 2;
    do_reset();
    for (int k = 1; k <= 340; k++) begin
      clk_n(1);
      if (k % 10 == 0) begin
        if (rem == 1) begin
          ph  = (ph + 1) % 6;
          rem = dur[ph];
        end else begin
          rem--;
        end
      end
      n_checks++;
      if (phase !== 3'(ph)) begin
        n_fail++;
        $display("FAIL free_phase @%0d: got %0d, want %0d", k, phase, ph);
      end
      n_checks++;
      if (remaining !== 6'(rem)) begin
        n_fail++;
        $display("FAIL free_rem @%0d: got %0d, want %0d", k, remaining, rem);
      end
      n_checks++;
      if ({R16, G16, R17, G17} !== exp_lights(ph)) begin
        n_fail++;
        $display("FAIL free_lights @%0d: got %b, want %b", k, {R16, G16, R17, G17}, exp_lights(ph));
      end
      n_checks++;
      if (sec_tick !== (k % 10 == 9)) begin
        n_fail++;
        $display("FAIL free_tick @%0d: got %b, want %b", k, sec_tick, (k % 10 == 9));
      end
    end
    n_checks++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL free_wrap: got phase=%0d, want 0", phase);
    end
  endtask

  task automatic test_ped_cut();
    do_reset();
    clk_n(40);                       // GREEN1, remaining 8
    BTNC = 1'b1;
    clk_n(2);                        // edge 42
    n_checks++;
    if (ped_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL cut_ped_early: got %b, want 0", ped_pending);
    end
    clk_n(1);                        // edge 43
    n_checks++;
    if ({ped_pending, remaining} !== {1'b1, 6'd8}) begin
      n_fail++;
      $display("FAIL cut_ped_set: got ped=%b rem=%0d, want 1/8", ped_pending, remaining);
    end
    clk_n(1);                        // edge 44
    n_checks++;
    if ({phase, remaining} !== {3'd1, 6'd3}) begin
      n_fail++;
      $display("FAIL cut_rem: got phase=%0d rem=%0d, want 1/3", phase, remaining);
    end
    clk_n(1);                        // edge 45
    BTNC = 1'b0;
    clk_n(24);                       // edge 69
    n_checks++;
    if ({phase, remaining} !== {3'd1, 6'd1}) begin
      n_fail++;
      $display("FAIL cut_last_green: got phase=%0d rem=%0d, want 1/1", phase, remaining);
    end
    clk_n(1);                        // edge 70
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd2, 6'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL cut_yel1: got phase=%0d rem=%0d ped=%b, want 2/5/1", phase, remaining, ped_pending);
    end
    clk_n(49);                       // edge 119
    n_checks++;
    if ({phase, ped_pending} !== {3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL cut_before_allredb: got phase=%0d ped=%b, want 2/1", phase, ped_pending);
    end
    clk_n(1);                        // edge 120
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd3, 6'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL cut_clear: got phase=%0d rem=%0d ped=%b, want 3/2/0", phase, remaining, ped_pending);
    end
  endtask

  task automatic test_late_request();
    do_reset();
    clk_n(270);                      // GREEN2, remaining 2
    BTNC = 1'b1;
    clk_n(4);                        // edge 274
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd4, 6'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL late_nocut: got phase=%0d rem=%0d ped=%b, want 4/2/1", phase, remaining, ped_pending);
    end
    clk_n(1);
    BTNC = 1'b0;
    clk_n(64);                       // edge 339
    n_checks++;
    if ({phase, ped_pending} !== {3'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL late_held: got phase=%0d ped=%b, want 5/1", phase, ped_pending);
    end
    clk_n(1);                        // edge 340
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd0, 6'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL late_clear: got phase=%0d rem=%0d ped=%b, want 0/2/0", phase, remaining, ped_pending);
    end
  endtask

  task automatic test_allred_request();
    do_reset();
    clk_n(1);
    BTNC = 1'b1;
    clk_n(5);                        // edge 6
    BTNC = 1'b0;
    n_checks++;
    if ({phase, ped_pending} !== {3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL allred_ped: got phase=%0d ped=%b, want 0/1", phase, ped_pending);
    end
    clk_n(14);                       // edge 20
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd1, 6'd10, 1'b1}) begin
      n_fail++;
      $display("FAIL allred_green_load: got phase=%0d rem=%0d ped=%b, want 1/10/1", phase, remaining, ped_pending);
    end
    clk_n(1);                        // edge 21
    n_checks++;
    if (remaining !== 6'd3) begin
      n_fail++;
      $display("FAIL allred_cut: got rem=%0d, want 3", remaining);
    end
    clk_n(28);                       // edge 49
    n_checks++;
    if ({phase, remaining} !== {3'd1, 6'd1}) begin
      n_fail++;
      $display("FAIL allred_last_green: got phase=%0d rem=%0d, want 1/1", phase, remaining);
    end
    clk_n(1);                        // edge 50
    n_checks++;
    if ({phase, remaining} !== {3'd2, 6'd5}) begin
      n_fail++;
      $display("FAIL allred_yel1: got phase=%0d rem=%0d, want 2/5", phase, remaining);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    clk_n(130);                      // YEL1
    BTNC = 1'b1;
    clk_n(5);                        // edge 135
    BTNC = 1'b0;
    clk_n(32);                       // edge 167
    BTNC = 1'b1;                     // detected edge lands on edge 170
    clk_n(2);                        // edge 169
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd2, 6'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL coinc_before: got phase=%0d rem=%0d ped=%b, want 2/1/1", phase, remaining, ped_pending);
    end
    clk_n(1);                        // edge 170
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd3, 6'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL coinc_set_wins: got phase=%0d rem=%0d ped=%b, want 3/2/1", phase, remaining, ped_pending);
    end
    clk_n(2);
    BTNC = 1'b0;
    clk_n(18);                       // edge 190
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd4, 6'd10, 1'b1}) begin
      n_fail++;
      $display("FAIL coinc_green2: got phase=%0d rem=%0d ped=%b, want 4/10/1", phase, remaining, ped_pending);
    end
    clk_n(1);                        // edge 191
    n_checks++;
    if (remaining !== 6'd3) begin
      n_fail++;
      $display("FAIL coinc_cut: got rem=%0d, want 3", remaining);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    clk_n(195);                      // GREEN2, remaining 10
    BTNC = 1'b1;
    clk_n(4);                        // edge 199
    n_checks++;
    if ({phase, remaining, ped_pending} !== {3'd4, 6'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL async_pre: got phase=%0d rem=%0d ped=%b, want 4/3/1", phase, remaining, ped_pending);
    end
    clk_n(1);                        // edge 200
    BTNC = 1'b0;
    @(posedge CLK100MHZ);
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({phase, remaining, ped_pending, sec_tick} !== {3'd0, 6'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_state: got phase=%0d rem=%0d ped=%b tick=%b, want 0/2/0/0", phase, remaining, ped_pending, sec_tick);
    end
    n_checks++;
    if ({R16, G16, R17, G17} !== 4'b1010) begin
      n_fail++;
      $display("FAIL async_lights: got %b, want 1010", {R16, G16, R17, G17});
    end
    @(negedge CLK100MHZ);
    RST = 1'b0;
    clk_n(8);
    n_checks++;
    if (sec_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_tick_early: got %b, want 0", sec_tick);
    end
    clk_n(1);
    n_checks++;
    if (sec_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL async_tick_first: got %b, want 1", sec_tick);
    end
    clk_n(1);
    n_checks++;
    if ({sec_tick, phase, remaining} !== {1'b0, 3'd0, 6'd1}) begin
      n_fail++;
      $display("FAIL async_after_tick: got tick=%b phase=%0d rem=%0d, want 0/0/1", sec_tick, phase, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_cut();
    test_late_request();
    test_allred_request();
    test_coincident();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
